rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-port arbiter and long-latency scoreboard for the 32×32 register file. It shares the register file's single write port between the in-order pipeline writeback (WB) and an out-of-band long-latency unit (LLU, mul/div). It buffers LLU results in a 2-entry FIFO and tracks pending LLU destinations, raising an issue stall on RAW/WAW hazards. It sits between the WB stage, the LLU, the ID stage hazard logic and the register file write port.

## Interface
- `DEPTH`, 2: LLU result FIFO entries; power of two, at least 2.
- `STARVE_MAX`, 8: cycles an LLU result may wait before WB is held.

- `clk`, in, 1: clock; all state updates on posedge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `wb_we`, in, 1: pipeline WB wants to write.
- `wb_rd`, in, 5: pipeline WB destination.
- `wb_data`, in, 32: pipeline WB data.
- `wb_hold`, out, 1: WB write refused this cycle; WB stage must hold and re-present.
- `llu_valid`, in, 1: LLU result available.
- `llu_rd`, in, 5: LLU result destination.
- `llu_data`, in, 32: LLU result data.
- `llu_ready`, out, 1: FIFO accepts the LLU result this cycle.
- `iss_valid`, in, 1: an LLU op issues this cycle.
- `iss_rd`, in, 5: destination of the issuing LLU op.
- `id_rs1`, in, 5: ID source register 1.
- `id_rs2`, in, 5: ID source register 2.
- `id_rd`, in, 5: ID destination register.
- `id_we`, in, 1: ID instruction writes `id_rd`.
- `raw_stall`, out, 1: ID must stall.
- `rf_we`, out, 1: register file write enable.
- `rf_waddr`, out, 5: register file write address.
- `rf_wdata`, out, 32: register file write data.

## Operation
- **Push.** `llu_ready = !full`. A push occurs when `llu_valid && llu_ready`. There is no push-through when full, even if a pop happens in the same cycle.
- **WB request.** `wb_req = wb_we && wb_rd != 0`.
- **Pop (drain).** A pop occurs when the FIFO is non-empty and either `!wb_req` or `starve_hit`.
- **Write port mux.**
  - Pop cycle: `rf_we = (head.rd != 0)`, `rf_waddr = head.rd`, `rf_wdata = head.data`.
  - Otherwise: WB fields pass through, with `rf_we = wb_req`.
- **WB hold.** `wb_hold = pop && wb_req`. This can only be true under starvation.
- **Starvation counter.**
  - Increments on each cycle where the FIFO is non-empty and no pop occurs.
  - Saturates at `STARVE_MAX`.
  - Clears on pop, and when the FIFO is empty.
  - `starve_hit = (cnt == STARVE_MAX)`.
- **Scoreboard.** A 32-bit `pending` vector.
  - Set: `pending[iss_rd]` on `iss_valid && iss_rd != 0`.
  - Clear: `pending[head.rd]` on pop.
  - Bit 0 is always 0.
  - If set and clear hit the same bit in the same cycle, set wins.
- **Stall.** `raw_stall = pending[id_rs1] | pending[id_rs2] | (id_we & pending[id_rd])`, with index 0 contributing 0.
- All outputs except FIFO/counter/pending state are combinational from inputs and state.

## Timing
- **Reset values.** FIFO empty, `cnt = 0`, `pending = 0`. Resulting outputs: `llu_ready = 1`, `wb_hold = 0`, `raw_stall = 0`, and `rf_we = wb_req` (0 with idle inputs).
- **Write latency.** The register file samples `rf_*` on the negedge of the same cycle. An LLU result pushed in cycle N can reach `rf_we` in cycle N+1 at the earliest.
- **Stall release.** `raw_stall` deasserts in the cycle after the clearing pop.
- **Reset mid-operation.** Buffered results and pending bits are discarded. The LLU is flushed by the same `rst`.
- **FIFO wrap-around.** Pointers are `log2(DEPTH)+1` bits. Full when MSBs differ and the remaining bits are equal.

## Configuration
- `RF_WB_STARVE_EN` defined: counter and `wb_hold` are present as described.
- Undefined:
  - The counter is absent.
  - `starve_hit` is constant 0 and `wb_hold` is tied to 0.
  - Pops occur only on cycles without a WB request.
  - LLU progress relies on WB bubbles.

## Structure
- **Package `rf_wb_pkg`.**
  - `XLEN = 32`.
  - `REG_AW = 5`.
  - `NREG = 32`.
  - Typedef `llu_entry_t {rd[4:0], data[31:0]}`.
- **Sub-module `rf_wb_fifo`.**
  - Parameterised on `DEPTH`.
  - Ports: push/pop, `full`, `empty`, `head`.
  - Async-reset pointers.
- Arbitration, counter and scoreboard live in the top module.

## Test plan
- **Idle WB drain.** `iss_valid rd=5`, then `llu_valid rd=5 data=0xDEAD` with `wb_we=0` → next cycle `rf_we=1 waddr=5 wdata=0xDEAD`, and `pending[5]` clears.
- **RAW stall.** `pending[7]=1`, `id_rs2=7` → `raw_stall=1` until the pop of rd 7; 0 the cycle after. `id_rs1=0` never stalls.
- **Full FIFO.** Push 2 results while `wb_we=1 wb_rd=3` continuously → `llu_ready=0`, and WB writes rd 3 each cycle.
- **Starvation (macro on).** Continuous `wb_req` with a non-empty FIFO → at cycle 8 of waiting: `wb_hold=1`, head written, counter cleared.
- **x0 entry.** LLU result with `rd=0` → popped with `rf_we=0`, pending unchanged.
- **Async reset.** `rst` pulse mid-operation with the FIFO full → `llu_ready=1`, `pending=0`, and no spurious `rf_we`.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared widths and the LLU result payload for the register-file write arbiter.
package rf_wb_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } llu_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small LLU result FIFO; pointers carry one extra wrap bit to separate full from empty.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  llu_entry_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output llu_entry_t head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  llu_entry_t    mem [DEPTH];

  // Pointer advance; callers only push when not full and pop when not empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  // Payload storage needs no reset: it is only read while non-empty.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= din;
  end

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between pipeline WB and the long-latency unit,
// with a pending-destination scoreboard driving the ID stall.
// Optional starvation relief (counter + wb_hold) is built when RF_WB_STARVE_EN is defined;
// without it, buffered LLU results drain only on WB bubbles.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              wb_hold,
  input  logic              llu_valid,
  input  logic [REG_AW-1:0] llu_rd,
  input  logic [XLEN-1:0]   llu_data,
  output logic              llu_ready,
  input  logic              iss_valid,
  input  logic [REG_AW-1:0] iss_rd,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  output logic              raw_stall,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata
);

  // Reject configurations the pointer and counter logic cannot represent.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_MAX == 0) begin : g_bad_cfg
    $error("rf_wb_arbiter: DEPTH must be a power of two >= 2 and STARVE_MAX >= 1");
  end

  logic       wb_req;
  logic       push;
  logic       pop;
  logic       full;
  logic       empty;
  logic       starve_hit;
  llu_entry_t din;
  llu_entry_t head;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] set_v;
  logic [NREG-1:0] clr_v;

  assign wb_req    = wb_we && (wb_rd != '0);
  assign llu_ready = !full;
  assign push      = llu_valid && !full;
  assign pop       = !empty && (!wb_req || starve_hit);
  assign din       = '{rd: llu_rd, data: llu_data};

  rf_wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .pop   (pop),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

`ifdef RF_WB_STARVE_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] cnt_q;

  // Count cycles a buffered result has waited behind WB; saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (pop || empty) begin
      cnt_q <= '0;
    end else if (!starve_hit) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign starve_hit = (cnt_q == CW'(STARVE_MAX));
  assign wb_hold    = pop && wb_req;
`else
  assign starve_hit = 1'b0;
  assign wb_hold    = 1'b0;
`endif

  // Write-port mux: a draining FIFO head takes the port, otherwise WB passes through.
  always_comb begin
    rf_we    = wb_req;
    rf_waddr = wb_rd;
    rf_wdata = wb_data;
    if (pop) begin
      rf_we    = (head.rd != '0);
      rf_waddr = head.rd;
      rf_wdata = head.data;
    end
  end

  // Scoreboard set/clear masks for this cycle.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (iss_valid && (iss_rd != '0)) set_v[iss_rd] = 1'b1;
    if (pop) clr_v[head.rd] = 1'b1;
  end

  // Pending LLU destinations; issue beats drain on the same bit, x0 never pends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= ((pending_q & ~clr_v) | set_v) & ~NREG'(1);
    end
  end

  assign raw_stall = pending_q[id_rs1] | pending_q[id_rs2] | (id_we & pending_q[id_rd]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a reference queue/scoreboard model.
module tb_rf_wb_arbiter;
  import rf_wb_pkg::*;

  localparam int unsigned SMAX = 8;

  logic              clk;
  logic              rst;
  logic              wb_we;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              wb_hold;
  logic              llu_valid;
  logic [REG_AW-1:0] llu_rd;
  logic [XLEN-1:0]   llu_data;
  logic              llu_ready;
  logic              iss_valid;
  logic [REG_AW-1:0] iss_rd;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              raw_stall;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  rf_wb_arbiter #(.DEPTH(2), .STARVE_MAX(SMAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_hold   (wb_hold),
    .llu_valid (llu_valid),
    .llu_rd    (llu_rd),
    .llu_data  (llu_data),
    .llu_ready (llu_ready),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_rd     (id_rd),
    .id_we     (id_we),
    .raw_stall (raw_stall),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int hold_seen = 0;

  // Reference model state: buffered results, pending bits, wait counter.
  llu_entry_t  sbq[$];
  logic [31:0] pend = '0;
  int          scnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    pend = '0;
    scnt = 0;
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model at the posedge.
  task automatic step(input string tag);
    logic       req;
    logic       hit;
    logic       pp;
    logic       exp_stall;
    logic       was_empty;
    llu_entry_t h;
    #3;
    req = wb_we && (wb_rd != 0);
`ifdef RF_WB_STARVE_EN
    hit = (scnt == SMAX);
`else
    hit = 1'b0;
`endif
    pp = (sbq.size() != 0) && (!req || hit);
    h  = '0;
    if (pp) h = sbq[0];
    exp_stall = pend[id_rs1] | pend[id_rs2] | (id_we & pend[id_rd]);
    chk({tag, ".llu_ready"}, 32'(llu_ready), 32'(sbq.size() < 2));
    chk({tag, ".wb_hold"},   32'(wb_hold),   32'(pp && req));
    chk({tag, ".raw_stall"}, 32'(raw_stall), 32'(exp_stall));
    chk({tag, ".rf_we"},     32'(rf_we),     pp ? 32'(h.rd != 0) : 32'(req));
    if (pp) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(h.rd));
      chk({tag, ".rf_wdata"}, rf_wdata, h.data);
    end else if (req) begin
      chk({tag, ".rf_waddr"}, 32'(rf_waddr), 32'(wb_rd));
      chk({tag, ".rf_wdata"}, rf_wdata, wb_data);
    end
    if (wb_hold === 1'b1) hold_seen++;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      was_empty = (sbq.size() == 0);
      if (pp) begin
        void'(sbq.pop_front());
        pend[h.rd] = 1'b0;
      end
      if (pp || was_empty) scnt = 0;
      else if (scnt < SMAX) scnt++;
      if (llu_valid && (sbq.size() < 2 + (pp ? 1 : 0)) && !(was_empty == 1'b0 && sbq.size() + (pp ? 1 : 0) >= 2))
        sbq.push_back('{rd: llu_rd, data: llu_data});
      if (iss_valid && iss_rd != 0) pend[iss_rd] = 1'b1;
      pend[0] = 1'b0;
    end
    #1;
  endtask

  task automatic set_llu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    llu_valid = v; llu_rd = rd; llu_data = d;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
    wb_we = we; wb_rd = rd; wb_data = d;
  endtask

  task automatic set_iss(input logic v, input logic [4:0] rd);
    iss_valid = v; iss_rd = rd;
  endtask

  initial begin
    rst = 1'b1;
    set_wb(0, 0, 0); set_llu(0, 0, 0); set_iss(0, 0);
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_we = 0;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    step("idle");

    // Idle WB drain of an LLU result to rd 5.
    set_iss(1, 5); id_rs1 = 5;
    step("drain_iss");
    set_iss(0, 0);
    set_llu(1, 5, 32'hDEAD);
    step("drain_push");
    set_llu(0, 0, 0);
    step("drain_pop");
    chk("drain_released", 32'(raw_stall), 32'd0);
    step("drain_after");
    id_rs1 = 0;

    // RAW stall on rs2 held while WB keeps the port busy.
    set_iss(1, 7); id_rs2 = 7;
    step("raw_iss");
    set_iss(0, 0);
    set_wb(1, 3, 32'h30);
    set_llu(1, 7, 32'h77);
    step("raw_push");
    set_llu(0, 0, 0);
    step("raw_blocked");
    set_wb(0, 0, 0);
    step("raw_pop");
    step("raw_release");
    chk("raw_rs1_zero", 32'(raw_stall), 32'd0);
    id_rs2 = 0;

    // Full FIFO under continuous WB writes to rd 3.
    set_iss(1, 9);  step("full_iss9");
    set_iss(1, 10); step("full_iss10");
    set_iss(0, 0);
    set_wb(1, 3, 32'h300); set_llu(1, 9, 32'h900);  step("full_push9");
    set_wb(1, 3, 32'h301); set_llu(1, 10, 32'hA00); step("full_push10");
    set_wb(1, 3, 32'h302); set_llu(1, 11, 32'hB00); step("full_reject");
    set_llu(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      set_wb(1, 3, 32'h310 + 32'(i));
      step("full_wb");
    end
`ifdef RF_WB_STARVE_EN
    chk("starve_hold_seen", 32'(hold_seen != 0), 32'd1);
`else
    chk("no_hold_seen", 32'(hold_seen), 32'd0);
`endif
    set_wb(0, 0, 0);
    step("full_drain0");
    step("full_drain1");
    step("full_drain2");

    // x0 result: popped without a write, scoreboard untouched.
    set_iss(1, 12); step("x0_iss");
    set_iss(0, 0); id_rd = 12; id_we = 1;
    set_llu(1, 0, 32'h1234); step("x0_push");
    set_llu(0, 0, 0); step("x0_pop");
    chk("x0_pending_kept", 32'(raw_stall), 32'd1);
    step("x0_after");

    // Asynchronous reset with the FIFO full.
    set_wb(1, 3, 32'h500);
    set_llu(1, 12, 32'hC00); step("rst_push12");
    set_llu(1, 4, 32'h400);  step("rst_push4");
    set_llu(0, 0, 0);
    step("rst_full");
    #2;
    rst = 1'b1;
    set_wb(0, 0, 0);
    #1;
    model_reset();
    chk("async_ready",  32'(llu_ready), 32'd1);
    chk("async_stall",  32'(raw_stall), 32'd0);
    chk("async_rf_we",  32'(rf_we),     32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_rst0");
    step("post_rst1");
    id_rd = 0; id_we = 0;
    step("post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
